// File: rtl/xmodem_imem_loader.sv
// xmodem_imem_loader: XMODEM (checksum) receiver that streams 128-byte
// payloads into instruction memory as little-endian words and answers
// ACK/NAK through the UART TX FIFO. Raises o_done after the EOT handshake.
`timescale 1ns/1ps
module xmodem_imem_loader #(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 7,
  parameter int NB_UART_DATA    = 8
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
  input  logic                       i_uart_rx_empty,
  output logic                       o_uart_rd,
  output logic [NB_UART_DATA-1:0]    o_uart_wdata,
  output logic                       o_uart_wr,
  output logic                       o_uart_tx_start,
  input  logic                       i_uart_tx_done,
  output logic                       o_imem_wr,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam logic [NB_UART_DATA-1:0] SOH = NB_UART_DATA'(8'h01);
  localparam logic [NB_UART_DATA-1:0] EOT = NB_UART_DATA'(8'h04);
  localparam logic [NB_UART_DATA-1:0] ACK = NB_UART_DATA'(8'h06);
  localparam logic [NB_UART_DATA-1:0] NAK = NB_UART_DATA'(8'h15);
  localparam int WORDS_PER_BLOCK = 32;
  localparam int WORD_LOW_BITS   = NB_INSTRUCTION - NB_UART_DATA;

  typedef enum logic [2:0] {IDLE, BLK, BLKN, DATA, CKSUM, RESP, WAIT_TX} state_t;

  state_t                       state;
  state_t                       state_next;
  logic                         take;
  logic                         gap;
  logic [6:0]                   byte_cnt;
  logic [NB_UART_DATA-1:0]      cksum;
  logic [NB_UART_DATA-1:0]      blk;
  logic [NB_UART_DATA-1:0]      blkn;
  logic [NB_UART_DATA-1:0]      expected;
  logic [IMEM_ADDR_WIDTH-1:0]   base;
  logic [WORD_LOW_BITS-1:0]     word;
  logic                         eot;
  logic [NB_UART_DATA-1:0]      resp;
  logic                         imem_wr_pend;
  logic                         busy;
  logic                         done;
  logic                         hdr_ok;
  logic                         sum_ok;

  // Header is consistent when block number and its complement agree.
  assign hdr_ok = ((blk ^ blkn) == '1);
  assign sum_ok = (cksum == i_uart_rx_data);

  // State register.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, RX pop and TX strobes; nothing moves while i_en is low.
  always_comb begin
    state_next      = state;
    take            = 1'b0;
    o_uart_wr       = 1'b0;
    o_uart_tx_start = 1'b0;
    if (i_en) begin
      case (state)
        IDLE, BLK, BLKN, DATA, CKSUM: take = !i_uart_rx_empty && !gap;
        RESP: begin
          o_uart_wr       = 1'b1;
          o_uart_tx_start = 1'b1;
          state_next      = WAIT_TX;
        end
        WAIT_TX: if (i_uart_tx_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
      if (take) begin
        case (state)
          IDLE: begin
            if (i_uart_rx_data == SOH)      state_next = BLK;
            else if (i_uart_rx_data == EOT) state_next = RESP;
          end
          BLK:   state_next = BLKN;
          BLKN:  state_next = DATA;
          DATA:  if (byte_cnt == 7'd127) state_next = CKSUM;
          CKSUM: state_next = RESP;
          default: state_next = state;
        endcase
      end
    end
  end

  assign o_uart_rd    = take;
  assign o_uart_wdata = resp;
  assign o_imem_wr    = imem_wr_pend && i_en;
  assign o_busy       = busy;
  assign o_done       = done;

  // Datapath: header capture, checksum, word assembly, IMEM write, response
  // selection and block bookkeeping. The gap flag starts set so no pop can
  // be issued during or straight out of reset.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      gap          <= 1'b1;
      byte_cnt     <= '0;
      cksum        <= '0;
      blk          <= '0;
      blkn         <= '0;
      expected     <= NB_UART_DATA'(1);
      base         <= '0;
      word         <= '0;
      eot          <= 1'b0;
      resp         <= '0;
      imem_wr_pend <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (i_en) begin
      gap          <= take;
      imem_wr_pend <= 1'b0;
      case (state)
        IDLE: if (take) begin
          if (i_uart_rx_data == SOH) begin
            cksum    <= '0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            if (done) begin
              base     <= '0;
              expected <= NB_UART_DATA'(1);
              done     <= 1'b0;
            end
          end else if (i_uart_rx_data == EOT) begin
            resp <= ACK;
            eot  <= 1'b1;
          end
        end
        BLK:  if (take) blk  <= i_uart_rx_data;
        BLKN: if (take) blkn <= i_uart_rx_data;
        DATA: if (take) begin
          cksum    <= cksum + i_uart_rx_data;
          word     <= {i_uart_rx_data, word[WORD_LOW_BITS-1:NB_UART_DATA]};
          byte_cnt <= byte_cnt + 7'd1;
          if (byte_cnt[1:0] == 2'd3) begin
            imem_wr_pend <= 1'b1;
            o_imem_addr  <= base + IMEM_ADDR_WIDTH'(byte_cnt[6:2]);
            o_imem_wdata <= {i_uart_rx_data, word};
          end
        end
        CKSUM: if (take) begin
          if (hdr_ok && sum_ok && blk == expected) begin
            resp     <= ACK;
            base     <= base + IMEM_ADDR_WIDTH'(WORDS_PER_BLOCK);
            expected <= expected + NB_UART_DATA'(1);
          end else if (hdr_ok && sum_ok && blk == expected - NB_UART_DATA'(1)) begin
            resp <= ACK;
          end else begin
            resp <= NAK;
          end
        end
        WAIT_TX: if (i_uart_tx_done) begin
          busy <= 1'b0;
          if (eot) begin
            done     <= 1'b1;
            eot      <= 1'b0;
            base     <= '0;
            expected <= NB_UART_DATA'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xmodem_imem_loader.sv
// Testbench for xmodem_imem_loader: models the RX FIFO and TX responder,
// predicts responses and IMEM writes from the XMODEM rules.
`timescale 1ns/1ps
module tb_xmodem_imem_loader;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b1;
  logic [7:0]  i_uart_rx_data = 8'h00;
  logic        i_uart_rx_empty = 1'b1;
  logic        i_uart_tx_done = 1'b0;
  logic        o_uart_rd;
  logic [7:0]  o_uart_wdata;
  logic        o_uart_wr;
  logic        o_uart_tx_start;
  logic        o_imem_wr;
  logic [6:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_busy;
  logic        o_done;

  xmodem_imem_loader #(.NB_INSTRUCTION(32), .IMEM_ADDR_WIDTH(7), .NB_UART_DATA(8)) dut (
    .clk(clk), .i_rst(i_rst), .i_en(i_en),
    .i_uart_rx_data(i_uart_rx_data), .i_uart_rx_empty(i_uart_rx_empty),
    .o_uart_rd(o_uart_rd), .o_uart_wdata(o_uart_wdata), .o_uart_wr(o_uart_wr),
    .o_uart_tx_start(o_uart_tx_start), .i_uart_tx_done(i_uart_tx_done),
    .o_imem_wr(o_imem_wr), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Bench-side FIFO, logs and responder state
  logic [7:0]  rxq[$];
  logic [6:0]  wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          wlog_cyc[$];
  logic [7:0]  txlog[$];
  int          txcyc[$];
  int          rdcyc[$];
  int  cyc = 0;
  bit  pop_pending = 0;
  bit  rd_prev = 0;
  bit  done_prev = 0;
  bit  en_random = 0;
  int  tx_timer = 0;
  int  txdone_count = 0;
  int  last_txdone_cyc = -100;
  int  done_rise_cyc = -100;
  int  rule_bad = 0;

  // Reference model state
  int  m_base = 0;
  int  m_exp = 1;
  bit  m_done = 0;
  logic [7:0] pay [128];

  // Drive FIFO head / enable / tx_done at the falling edge, then sample outputs.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pop_pending && rxq.size() > 0) void'(rxq.pop_front());
    pop_pending = 0;
    i_en = en_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    i_uart_tx_done = 1'b0;
    if (tx_timer == 1) begin
      if (i_en) begin
        i_uart_tx_done = 1'b1;
        tx_timer = 0;
        txdone_count++;
        last_txdone_cyc = cyc;
      end
    end else if (tx_timer > 1) begin
      tx_timer--;
    end
    i_uart_rx_empty = (rxq.size() == 0);
    i_uart_rx_data = (rxq.size() == 0) ? 8'h00 : rxq[0];
    #1;
    if (o_uart_rd === 1'b1) begin
      if (rd_prev || i_uart_rx_empty) rule_bad++;
      rdcyc.push_back(cyc);
      pop_pending = 1;
    end
    rd_prev = (o_uart_rd === 1'b1);
    if (o_imem_wr === 1'b1) begin
      wlog_addr.push_back(o_imem_addr);
      wlog_data.push_back(o_imem_wdata);
      wlog_cyc.push_back(cyc);
    end
    if (o_uart_wr !== o_uart_tx_start) rule_bad++;
    if (o_uart_wr === 1'b1) begin
      txlog.push_back(o_uart_wdata);
      txcyc.push_back(cyc);
      tx_timer = 4;
    end
    if (o_done === 1'b1 && !done_prev) done_rise_cyc = cyc;
    done_prev = (o_done === 1'b1);
  end

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
    txlog.delete(); txcyc.delete(); rdcyc.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 128; i++) pay[i] = 8'($urandom);
  endtask

  // Send one packet and check response, writes and timing against the model.
  task automatic run_packet(input string name, input int blk, input int blkn,
                            input int ck_delta, input bit trickle);
    int sum, exp_resp, start_base, budget, start_cnt, nw;
    logic [7:0] b8, bn8, ck8, got_resp;
    logic [31:0] exp_word;
    logic [6:0] exp_addr;
    sum = 0;
    for (int i = 0; i < 128; i++) sum += pay[i];
    sum = (sum + ck_delta) & 255;
    ck8 = 8'(sum); b8 = 8'(blk); bn8 = 8'(blkn);
    if (m_done) begin m_base = 0; m_exp = 1; m_done = 0; end
    start_base = m_base;
    if (((blk ^ blkn) & 255) == 255 && ck_delta == 0 && blk == m_exp) begin
      exp_resp = 8'h06; m_base = (m_base + 32) % 128; m_exp = (m_exp + 1) % 256;
    end else if (((blk ^ blkn) & 255) == 255 && ck_delta == 0 && blk == (m_exp + 255) % 256) begin
      exp_resp = 8'h06;
    end else begin
      exp_resp = 8'h15;
    end
    clear_logs();
    start_cnt = txdone_count;
    rxq.push_back(8'h01); rxq.push_back(b8); rxq.push_back(bn8);
    for (int i = 0; i < 128; i++) begin
      rxq.push_back(pay[i]);
      if (trickle) repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    rxq.push_back(ck8);
    budget = 0;
    while (txdone_count == start_cnt && budget < 4000) begin
      @(negedge clk); budget++;
    end
    @(negedge clk); #2;
    total++;
    if (budget >= 4000) begin bad++; $display("FAIL %s_timeout: no tx_done after %0d cycles, required within 4000", name, budget); end
    got_resp = (txlog.size() > 0) ? txlog[0] : 8'hxx;
    total++;
    if (txlog.size() != 1 || got_resp !== 8'(exp_resp)) begin
      bad++; $display("FAIL %s_resp: got %0d bytes first=%02h, required 1 byte %02h", name, txlog.size(), got_resp, exp_resp);
    end
    nw = wlog_addr.size();
    total++;
    if (nw != 32) begin bad++; $display("FAIL %s_wcount: got %0d writes, required 32", name, nw); end
    for (int i = 0; i < 32 && i < nw; i++) begin
      exp_addr = 7'((start_base + i) % 128);
      exp_word = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
      total++;
      if (wlog_addr[i] !== exp_addr || wlog_data[i] !== exp_word) begin
        bad++; $display("FAIL %s_write%0d: got addr %0d data %08h, required addr %0d data %08h",
                        name, i, wlog_addr[i], wlog_data[i], exp_addr, exp_word);
      end
    end
    if (!en_random && nw > 0 && rdcyc.size() >= 7) begin
      total++;
      if (wlog_cyc[0] != rdcyc[6] + 1) begin
        bad++; $display("FAIL %s_wr_latency: first write cycle %0d, required %0d", name, wlog_cyc[0], rdcyc[6] + 1);
      end
    end
    if (!en_random && txcyc.size() > 0 && rdcyc.size() > 0) begin
      total++;
      if (txcyc[0] != rdcyc[rdcyc.size()-1] + 1) begin
        bad++; $display("FAIL %s_tx_latency: tx cycle %0d, required %0d", name, txcyc[0], rdcyc[rdcyc.size()-1] + 1);
      end
    end
    total++;
    if (o_busy !== 1'b0 || o_done !== m_done) begin
      bad++; $display("FAIL %s_flags: got busy=%b done=%b, required busy=0 done=%b", name, o_busy, o_done, m_done);
    end
    $display("packet %s blk=%0d blkn=%0d resp=%02h writes=%0d base_from=%0d", name, blk, blkn, got_resp, nw, start_base);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    total++;
    if ({o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_wr, o_busy, o_done} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %06b, required 000000",
                      {o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_wr, o_busy, o_done});
    end
    total++;
    if (o_imem_addr !== 7'd0 || o_imem_wdata !== 32'd0 || o_uart_wdata !== 8'd0) begin
      bad++; $display("FAIL reset_data: got addr=%0d wdata=%08h uart=%02h, required zeros", o_imem_addr, o_imem_wdata, o_uart_wdata);
    end
    @(posedge clk); #2; i_rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_good_block();
    pay[0] = 8'h13; pay[1] = 8'h01; pay[2] = 8'h40; pay[3] = 8'h00;
    pay[4] = 8'h93; pay[5] = 8'h01; pay[6] = 8'h40; pay[7] = 8'h00;
    for (int i = 8; i < 128; i++) pay[i] = 8'h1A;
    run_packet("good_blk1", m_exp, 255 - m_exp, 0, 0);
  endtask

  task automatic test_bad_checksum();
    fill_random();
    run_packet("bad_cksum", m_exp, 255 - m_exp, 1, 0);
    run_packet("retransmit", m_exp, 255 - m_exp, 0, 0);
  endtask

  task automatic test_bad_header();
    fill_random();
    run_packet("bad_hdr", m_exp, (255 - m_exp) ^ 2, 0, 0);
  endtask

  task automatic test_duplicate();
    run_packet("duplicate", (m_exp + 255) % 256, 255 - ((m_exp + 255) % 256), 0, 0);
  endtask

  task automatic test_random_blocks();
    int kind, b;
    for (int n = 0; n < 8; n++) begin
      fill_random();
      kind = $urandom_range(0, 4);
      b = (kind == 1) ? (m_exp + 255) % 256 : (kind == 4) ? (m_exp + 5) % 256 : m_exp;
      case (kind)
        2:       run_packet("rand_cksum", b, 255 - b, $urandom_range(1, 255), 1'($urandom_range(0, 1)));
        3:       run_packet("rand_hdr", b, (255 - b) ^ $urandom_range(1, 255), 0, 1'($urandom_range(0, 1)));
        default: run_packet("rand_blk", b, 255 - b, 0, 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  task automatic test_enable();
    en_random = 1;
    for (int n = 0; n < 2; n++) begin
      fill_random();
      run_packet("en_toggle", m_exp, 255 - m_exp, 0, 0);
    end
    en_random = 0;
    @(negedge clk);
  endtask

  task automatic test_eot();
    int start_cnt, budget;
    logic [7:0] got;
    clear_logs();
    start_cnt = txdone_count;
    budget = 0;
    rxq.push_back(8'h04);
    while (txdone_count == start_cnt && budget < 1000) begin
      @(negedge clk); budget++;
    end
    @(negedge clk); #2;
    got = (txlog.size() > 0) ? txlog[0] : 8'hxx;
    total++;
    if (txlog.size() != 1 || got !== 8'h06) begin
      bad++; $display("FAIL eot_resp: got %0d bytes first=%02h, required 1 byte 06", txlog.size(), got);
    end
    total++;
    if (done_rise_cyc != last_txdone_cyc + 1) begin
      bad++; $display("FAIL eot_done_timing: done rose cycle %0d, required %0d", done_rise_cyc, last_txdone_cyc + 1);
    end
    total++;
    if (o_done !== 1'b1) begin bad++; $display("FAIL eot_done_level: got %b, required 1", o_done); end
    m_done = 1; m_base = 0; m_exp = 1;
    $display("eot resp=%02h done=%b", got, o_done);
  endtask

  task automatic test_after_eot();
    fill_random();
    run_packet("after_eot", 1, 254, 0, 0);
  endtask

  task automatic test_reset_mid();
    int sum, budget;
    fill_random();
    clear_logs();
    sum = 0;
    for (int i = 0; i < 128; i++) sum += pay[i];
    rxq.push_back(8'h01); rxq.push_back(8'(m_exp)); rxq.push_back(8'(255 - m_exp));
    for (int i = 0; i < 128; i++) rxq.push_back(pay[i]);
    rxq.push_back(8'(sum));
    budget = 0;
    while (rdcyc.size() < 53 && budget < 1000) begin
      @(negedge clk); budget++;
    end
    total++;
    if (budget >= 1000) begin bad++; $display("FAIL rstmid_timeout: %0d bytes read, required 53", rdcyc.size()); end
    @(posedge clk); #2;
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_wr, o_busy, o_done} !== 6'b0) begin
      bad++; $display("FAIL rstmid_strobes: got %06b, required 000000",
                      {o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_wr, o_busy, o_done});
    end
    total++;
    if (o_imem_addr !== 7'd0 || o_imem_wdata !== 32'd0 || o_uart_wdata !== 8'd0) begin
      bad++; $display("FAIL rstmid_data: got addr=%0d wdata=%08h uart=%02h, required zeros", o_imem_addr, o_imem_wdata, o_uart_wdata);
    end
    rxq.delete();
    pop_pending = 0;
    tx_timer = 0;
    repeat (3) @(posedge clk);
    #2; i_rst = 1'b0;
    m_base = 0; m_exp = 1; m_done = 0;
    $display("reset asserted after data byte 50");
    fill_random();
    run_packet("after_rst", 1, 254, 0, 0);
  endtask

  task automatic test_protocol_rules();
    total++;
    if (rule_bad != 0) begin
      bad++; $display("FAIL protocol_rules: got %0d rd/tx_start violations, required 0", rule_bad);
    end
    $display("protocol rule violations=%0d", rule_bad);
  endtask

  initial begin
    test_reset();
    test_good_block();
    test_bad_checksum();
    test_bad_header();
    test_duplicate();
    test_random_blocks();
    test_enable();
    test_eot();
    test_after_eot();
    test_reset_mid();
    test_protocol_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
